// File: rtl/bus_interface_unit.sv
// bus_interface_unit
//   Registered bridge between the register file and the external memory bus.
//   Every rising clk edge, it decodes one bus command from SEL_BIU and the
//   register operands. The result appears on the bus one cycle later.
//
// Ports
//   clk                 in   system clock, rising edge
//   reset               in   asynchronous active-low reset; clears all outputs
//   NUM[2:0]            in   unsigned immediate offset for indexed reads
//   RX[7:0]             in   base address operand
//   RY[7:0]             in   write-data operand
//   SEL_BIU[1:0]        in   00 read, 01 write, 10 indexed read, 11 idle
//   o_Address_Data_Bus  out  registered address
//   o_DataOut_Bus       out  registered write data (zero unless writing)
//   W_R                 out  1 = write, 0 = read/idle
module bus_interface_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] NUM,
  input  logic [7:0] RX,
  input  logic [7:0] RY,
  input  logic [1:0] SEL_BIU,
  output logic [7:0] o_Address_Data_Bus,
  output logic [7:0] o_DataOut_Bus,
  output logic       W_R
);

  localparam logic [1:0] CMD_READ  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_IDXRD = 2'b10;

  logic [7:0] addr_d;
  logic [7:0] data_d;
  logic       wr_d;

  // Next bus state. Any encoding not listed decodes as idle, including
  // 2'b11. This keeps the bus quiet, with zero data and the strobe low.
  always_comb begin
    addr_d = 8'h00;
    data_d = 8'h00;
    wr_d   = 1'b0;
    case (SEL_BIU)
      CMD_READ:  addr_d = RX;
      CMD_WRITE: begin
        addr_d = RX;
        data_d = RY;
        wr_d   = 1'b1;
      end
      // The offset is zero-extended. The sum wraps modulo 256.
      CMD_IDXRD: addr_d = RX + {5'b0, NUM};
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_Address_Data_Bus <= 8'h00;
      o_DataOut_Bus      <= 8'h00;
      W_R                <= 1'b0;
    end else begin
      o_Address_Data_Bus <= addr_d;
      o_DataOut_Bus      <= data_d;
      W_R                <= wr_d;
    end
  end

endmodule

// File: tb/tb_bus_interface_unit.sv
// Directed bench for bus_interface_unit. The expected values are hand-computed.
module tb_bus_interface_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] NUM;
  logic [7:0] RX, RY;
  logic [1:0] SEL_BIU;
  logic [7:0] o_Address_Data_Bus, o_DataOut_Bus;
  logic       W_R;

  int n_chk = 0;
  int n_err = 0;

  bus_interface_unit dut (
    .clk                (clk),
    .reset              (reset),
    .NUM                (NUM),
    .RX                 (RX),
    .RY                 (RY),
    .SEL_BIU            (SEL_BIU),
    .o_Address_Data_Bus (o_Address_Data_Bus),
    .o_DataOut_Bus      (o_DataOut_Bus),
    .W_R                (W_R)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge. Inputs are driven and
  // outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bus(input string tag, input logic [7:0] a, input logic [7:0] d, input logic w);
    chk({tag, ".addr"}, o_Address_Data_Bus, a);
    chk({tag, ".data"}, o_DataOut_Bus, d);
    chk({tag, ".wr"},   {7'b0, W_R}, {7'b0, w});
  endtask

  initial begin
    reset = 1'b0; RX = 8'd7; RY = 8'd6; NUM = 3'd2; SEL_BIU = 2'b11;
    #1;
    chk_bus("rst_async", 8'h00, 8'h00, 1'b0);
    step(); step();
    chk_bus("rst_held", 8'h00, 8'h00, 1'b0);
    reset = 1'b1;
    step();
    chk_bus("idle_after_rst", 8'h00, 8'h00, 1'b0);

    // read
    SEL_BIU = 2'b00; step();
    chk_bus("read", 8'd7, 8'h00, 1'b0);
    // write, then back to read
    SEL_BIU = 2'b01; step();
    chk_bus("write", 8'd7, 8'd6, 1'b1);
    SEL_BIU = 2'b00; step();
    chk_bus("read_after_wr", 8'd7, 8'h00, 1'b0);
    // indexed reads, including wrap
    SEL_BIU = 2'b10; RX = 8'd7; NUM = 3'd2; step();
    chk_bus("idx", 8'd9, 8'h00, 1'b0);
    RX = 8'hFE; NUM = 3'd3; step();
    chk_bus("idx_wrap", 8'h01, 8'h00, 1'b0);
    RX = 8'hFF; NUM = 3'd0; step();
    chk_bus("idx_ff0", 8'hFF, 8'h00, 1'b0);
    RX = 8'hFF; NUM = 3'd7; step();
    chk_bus("idx_ff7", 8'h06, 8'h00, 1'b0);
    // write directly followed by idle
    SEL_BIU = 2'b01; RX = 8'h12; RY = 8'h34; step();
    chk_bus("write2", 8'h12, 8'h34, 1'b1);
    SEL_BIU = 2'b11; step();
    chk_bus("idle_after_wr", 8'h00, 8'h00, 1'b0);

    // reset in the middle of a write, between edges
    SEL_BIU = 2'b01; RX = 8'hA5; RY = 8'h3C; step();
    chk_bus("wr_pre_rst", 8'hA5, 8'h3C, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk_bus("rst_mid_wr", 8'h00, 8'h00, 1'b0);
    reset = 1'b1;
    #1;
    chk_bus("rst_release", 8'h00, 8'h00, 1'b0);
    step();
    chk_bus("wr_post_rst", 8'hA5, 8'h3C, 1'b1);

    // mid-cycle glitch on RX and SEL_BIU, restored before the edge
    SEL_BIU = 2'b00; RX = 8'h10; step();
    chk_bus("glitch_base", 8'h10, 8'h00, 1'b0);
    #2 RX = 8'h55; SEL_BIU = 2'b01;
    #1;
    chk_bus("glitch_mid", 8'h10, 8'h00, 1'b0);
    RX = 8'h10; SEL_BIU = 2'b00;
    step();
    chk_bus("glitch_edge", 8'h10, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bus_interface_unit.md
Name: bus_interface_unit

Overview:
- Bus interface unit between the core register file and the external memory bus.
- Each clock it takes the two register operands (RX, RY), a 3-bit immediate offset (NUM) and a 2-bit bus command (SEL_BIU).
- It drives a registered address bus, a registered write-data bus and a write/read strobe.
- It sits between the control unit / register file and the memory/peripheral interconnect.

Parameters:
- None. All widths are fixed: 8-bit data/address, 3-bit offset, 2-bit command.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset (reset=0 clears all outputs immediately)
- NUM  input  3  unsigned immediate offset for indexed addressing
- RX  input  8  base address operand
- RY  input  8  write-data operand
- SEL_BIU  input  2  bus command (encoding below)
- o_Address_Data_Bus  output  8  registered memory address
- o_DataOut_Bus  output  8  registered write data
- W_R  output  1  bus direction strobe: 1 = write, 0 = read/idle

Behaviour:
- Reset: while reset=0, asynchronously force o_Address_Data_Bus=8'h00, o_DataOut_Bus=8'h00 and W_R=0. Outputs hold these values until the first rising clk edge after reset returns to 1.
- Latency: inputs are sampled on each rising clk edge when reset=1. Outputs reflect that sample from the same edge onward, giving a 1-cycle registered latency. No combinational path exists from inputs to outputs.
- Command decode, evaluated at each rising edge:
  - SEL_BIU=2'b00 (READ): address=RX, data=8'h00, W_R=0.
  - SEL_BIU=2'b01 (WRITE): address=RX, data=RY, W_R=1.
  - SEL_BIU=2'b10 (INDEXED READ): address=RX+{5'b0,NUM}, data=8'h00, W_R=0.
  - SEL_BIU=2'b11 (IDLE): address=8'h00, data=8'h00, W_R=0.
- Arithmetic:
  - NUM is zero-extended to 8 bits.
  - The sum is truncated to 8 bits, wrapping modulo 256; there is no carry output or flag.
- Bus hygiene:
  - o_DataOut_Bus is non-zero only during WRITE.
  - W_R is 1 only during WRITE.
  - No X or Z is ever driven.
- Back-to-back commands:
  - Any command may follow any other on consecutive cycles.
  - There is no handshake or wait state; each command occupies exactly one cycle.
- Input changes between clock edges have no effect on the outputs until the next rising edge.
- Reset mid-operation: asserting reset at any time, including during WRITE, clears all outputs asynchronously, without waiting for a clock edge. The first command after deassertion is taken at the next rising edge.
- X/unknown on SEL_BIU is not specified. Implementation decodes the default branch as IDLE.

Test Plan:
- Reset: reset=0 with RX=8'd7, RY=8'd6, NUM=3'd2, SEL_BIU=2'b11, clock running -> all outputs 0. Release reset -> outputs remain 0 (IDLE).
- READ: RX=7, RY=6, SEL_BIU=2'b00 -> after next rising edge: address=7, data=0, W_R=0.
- WRITE: RX=7, RY=6, SEL_BIU=2'b01 -> after next rising edge: address=7, data=6, W_R=1. Switch to SEL_BIU=2'b00 -> next edge W_R=0, data=0.
- INDEXED READ and wrap:
  - RX=7, NUM=2, SEL_BIU=2'b10 -> address=9, W_R=0.
  - RX=8'hFE, NUM=3 -> address=8'h01.
  - RX=8'hFF, NUM=0 -> address=8'hFF.
- Reset mid-WRITE: SEL_BIU=2'b01, RX=8'hA5, RY=8'h3C latched, then reset=0 between clock edges -> outputs 0 immediately. Deassert with SEL_BIU=2'b01 held -> next edge address=8'hA5, data=8'h3C, W_R=1.
- Input glitch: change RX and SEL_BIU mid-cycle, then restore them before the edge -> outputs unchanged until the edge and reflect only the values sampled at the edge.
